vga_color_scheduler: RTL and testbench
======================================

// Module: vga_color_scheduler
// PURPOSE
//  Frame-synchronous scheduler that shares the vga_display colour inputs (R_control/G_control/
//  B_control) between N_REQ requesters (lane-hit flashes, miss flash, score banner). Round-robin
//  grants one requester at a time. Colour changes only at a frame boundary, so no tearing.
//  Holds the granted colour for a requested number of whole frames, then returns to idle_color.
//  Sits between game logic and vga_display; vs is taken from vga_display's VS output.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  HOLD_W  4   width of per-requester frame-count field
// PORTS
//  clk          in   1             system clock (same domain as vga_display)
//  rst          in   1             asynchronous, active-low reset
//  vs           in   1             VS from vga_display; active-low sync pulse
//  req          in   N_REQ         request per requester; level, held until done or abort
//  color_in     in   8*N_REQ       per-requester colour {R[2:0],G[2:0],B[1:0]}, slice i = req i
//  frames_in    in   HOLD_W*N_REQ  per-requester hold length in frames; 0 is treated as 1
//  idle_color   in   8             colour shown when no grant is active
//  grant        out  N_REQ         one-hot grant; all-zero when idle
//  done         out  1             1-cycle pulse when the granted hold completes
//  busy         out  1             high in any state other than IDLE
//  R_control    out  3             to vga_display
//  G_control    out  3             to vga_display
//  B_control    out  2             to vga_display
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; grant=0; done=0; busy=0; R/G/B_control=0; rr pointer=0; vs_q=1.
//  Frame boundary (fb): vs_q==1 && vs==0, where vs_q is vs registered once. fb is 1 cycle per frame.
//  Outputs R/G/B_control are registered. They load only on an fb cycle, from:
//    - the latched colour in WAIT_FRAME;
//    - idle_color in IDLE and DRAIN, and in SHOW when the hold expires.
//  IDLE:
//    - if |req, pick the first set bit searching from ptr+1 (mod N_REQ).
//    - next cycle: grant=onehot(winner). colour and max(frames,1) are latched. state -> WAIT_FRAME.
//    - an fb in the same cycle as the pick loads idle_color. The granted colour waits for the next fb.
//  WAIT_FRAME: on fb, load the latched colour; cnt <= latched frames; state -> SHOW.
//  SHOW: on each fb, if cnt==1 load idle_color and go to RELEASE; else cnt <= cnt-1.
//    Result: the colour is shown for exactly `frames` full frames.
//  RELEASE (1 cycle): done=1; grant=0; ptr <= winner index; state -> IDLE.
//  Abort (granted req bit sampled low):
//    - in WAIT_FRAME: grant=0 next cycle; go to IDLE; no done; ptr unchanged.
//    - in SHOW: grant=0 next cycle; go to DRAIN; no done.
//    - DRAIN: on next fb load idle_color, ptr <= winner, go to IDLE.
//    - if abort and the expiring fb coincide in SHOW, expiry wins: RELEASE with done.
//  Latched colour and frame count are frozen while granted; changes to color_in/frames_in are ignored.
//  A requester still holding req after done is eligible again, but only after the other requesters in RR order.
//  Changes to req bits not granted have no effect during a grant.
//  busy = (state != IDLE). grant is a registered output; done is a registered output.
//  Latency: req→grant 1 cycle; grant→colour on screen at the first fb after grant; done at the fb of expiry +1 cycle.
//  Reset mid-hold: outputs return to 0 immediately. There is no resume.
// STRUCTURE
//  Shared package vga_pkg:
//    - COLOR_W=8, field slices R=[7:5], G=[4:2], B=[1:0];
//    - state encoding IDLE/WAIT_FRAME/SHOW/DRAIN/RELEASE.
//  Sub-module rr_arbiter #(N_REQ): combinational; (req, ptr) -> winner one-hot + index.
//  Top holds the FSM, vs edge detect, counter and colour registers.
// TESTING
//  1. Reset, idle_color=8'hFF, 2 fb -> R/G/B_control=7/7/3 after 1st fb; grant=0, busy=0.
//  2. req=0001, color0=8'hE0, frames0=3 -> grant=0001 next clk; R_control=7 from next fb for 3 frames;
//     then idle_color; done pulses once.
//  3. req=1111 with ptr=0 -> grants 0010,0100,1000,0001 in order; done after each; no two grants overlap.
//  4. frames0=0 -> held exactly 1 frame, then done.
//  5. req0 dropped during SHOW with frames0=5 -> grant=0 next clk; idle_color at next fb; no done.
//  6. rst low during SHOW -> outputs 0 immediately; after rst high, idle_color at first fb; new req regranted.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA colour path: colour field layout and scheduler states.
package vga_pkg;

  localparam int COLOR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    SHOW,
    DRAIN,
    RELEASE
  } sched_state_t;

  // Colour byte layout {R[2:0],G[2:0],B[1:0]}
  function automatic logic [2:0] color_r(input logic [COLOR_W-1:0] c);
    return c[7:5];
  endfunction

  function automatic logic [2:0] color_g(input logic [COLOR_W-1:0] c);
    return c[4:2];
  endfunction

  function automatic logic [1:0] color_b(input logic [COLOR_W-1:0] c);
    return c[1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    // k runs 1..N_REQ so the last-served requester is considered last
    for (int k = 1; k <= N_REQ; k++) begin
      if (!vld && req[(int'(ptr) + k) % N_REQ]) begin
        vld = 1'b1;
        idx = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/vga_color_scheduler.sv
// Frame-synchronous owner of the vga_display colour inputs; one requester at a time,
// colour only changes on the VS falling edge so a frame is never split.
module vga_color_scheduler
  import vga_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int HOLD_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vs,
  input  logic [N_REQ-1:0]          req,
  input  logic [COLOR_W*N_REQ-1:0]  color_in,
  input  logic [HOLD_W*N_REQ-1:0]   frames_in,
  input  logic [COLOR_W-1:0]        idle_color,
  output logic [N_REQ-1:0]          grant,
  output logic                      done,
  output logic                      busy,
  output logic [2:0]                R_control,
  output logic [2:0]                G_control,
  output logic [1:0]                B_control
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0][COLOR_W-1:0] color_a;
  logic [N_REQ-1:0][HOLD_W-1:0]  frames_a;
  assign color_a  = color_in;
  assign frames_a = frames_in;

  sched_state_t       state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               done_q, done_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic [HOLD_W-1:0]  frm_q, frm_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               vs_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  logic fb, abort;
  assign fb    = vs_q & ~vs;
  assign abort = ~req[win_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    rgb_d   = rgb_q;
    col_d   = col_q;
    frm_d   = frm_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (fb) rgb_d = idle_color;
        if (arb_vld) begin
          grant_d = arb_gnt;
          win_d   = arb_idx;
          col_d   = color_a[arb_idx];
          frm_d   = (frames_a[arb_idx] == '0) ? HOLD_W'(1) : frames_a[arb_idx];
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (abort) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (fb) begin
          rgb_d   = col_q;
          cnt_d   = frm_q;
          state_d = SHOW;
        end
      end
      SHOW: begin
        // Expiry outranks a simultaneous abort so a completed hold always reports done
        if (fb && cnt_q == HOLD_W'(1)) begin
          rgb_d   = idle_color;
          grant_d = '0;
          done_d  = 1'b1;
          state_d = RELEASE;
        end else if (abort) begin
          grant_d = '0;
          state_d = DRAIN;
        end else if (fb) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      DRAIN: begin
        if (fb) begin
          rgb_d   = idle_color;
          ptr_d   = win_q;
          state_d = IDLE;
        end
      end
      RELEASE: begin
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= 1'b0;
      rgb_q   <= '0;
      col_q   <= '0;
      frm_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      vs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rgb_q   <= rgb_d;
      col_q   <= col_d;
      frm_q   <= frm_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      vs_q    <= vs;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign R_control = color_r(rgb_q);
  assign G_control = color_g(rgb_q);
  assign B_control = color_b(rgb_q);

endmodule

// File: tb/tb_vga_color_scheduler.sv
// Randomized and directed check of vga_color_scheduler against a transaction-level model.
module tb_vga_color_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vs = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] color_in = '0;
  logic [15:0] frames_in = '0;
  logic [7:0]  idle_color = '0;
  logic [3:0]  grant;
  logic        done, busy;
  logic [2:0]  R_control, G_control;
  logic [1:0]  B_control;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  vga_color_scheduler #(.N_REQ(4), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .vs(vs), .req(req), .color_in(color_in),
    .frames_in(frames_in), .idle_color(idle_color), .grant(grant), .done(done),
    .busy(busy), .R_control(R_control), .G_control(G_control), .B_control(B_control)
  );

  always #5 clk = ~clk;

  // 10-cycle frames with a 2-cycle low sync pulse
  int vcnt = 5;
  always @(negedge clk) begin
    vcnt = (vcnt + 1) % 10;
    vs = (vcnt >= 2);
  end

  // Model: an owner with a colour to show for N frames, described by what has happened so far
  int          m_owner = -1;
  int          m_ptr = 0;
  int          m_left = 0;
  int          m_frames = 1;
  bit          m_showing = 0, m_drain = 0, m_rel = 0, m_done = 0, m_vsq = 1, m_fb_last = 0;
  logic [7:0]  m_col = '0, m_rgb = '0;

  always @(posedge clk or negedge rst) begin : model
    bit fb;
    bit found;
    int j;
    if (!rst) begin
      m_owner = -1; m_ptr = 0; m_showing = 0; m_drain = 0; m_rel = 0;
      m_done = 0; m_vsq = 1; m_fb_last = 0; m_rgb = '0;
    end else begin
      fb = m_vsq && !vs;
      m_vsq = vs;
      m_fb_last = fb;
      m_done = 0;
      if (m_rel) begin
        m_ptr = m_owner; m_owner = -1; m_rel = 0;
      end else if (m_owner < 0) begin
        if (fb) m_rgb = idle_color;
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          j = (m_ptr + k) % 4;
          if (!found && req[j]) begin found = 1; m_owner = j; end
        end
        if (found) begin
          m_col = color_in[m_owner*8 +: 8];
          m_frames = int'(frames_in[m_owner*4 +: 4]);
          if (m_frames == 0) m_frames = 1;
          m_showing = 0;
        end
      end else if (m_drain) begin
        if (fb) begin m_rgb = idle_color; m_ptr = m_owner; m_owner = -1; m_drain = 0; end
      end else if (!m_showing) begin
        if (!req[m_owner]) m_owner = -1;
        else if (fb) begin m_rgb = m_col; m_left = m_frames; m_showing = 1; end
      end else begin
        if (fb && m_left == 1) begin m_rgb = idle_color; m_rel = 1; m_done = 1; end
        else if (!req[m_owner]) m_drain = 1;
        else if (fb) m_left = m_left - 1;
      end
    end
  end

  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0 && !m_drain && !m_rel) g[m_owner] = 1'b1;
    return g;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      tests++;
      if ({grant, done, busy, R_control, G_control, B_control} !==
          {exp_grant(), m_done, (m_owner >= 0), m_rgb}) begin
        fails++;
        $display("FAIL cycle t=%0t: grant=%b done=%b busy=%b rgb=%h, model grant=%b done=%b busy=%b rgb=%h",
                 $time, grant, done, busy, {R_control, G_control, B_control},
                 exp_grant(), m_done, (m_owner >= 0), m_rgb);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_fb(input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_fb_last) return;
    end
    tests++; fails++;
    $display("FAIL %s: no frame boundary within bound", name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    tests++; fails++;
    $display("FAIL %s: busy did not clear within bound", name);
  endtask

  function automatic logic [7:0] rgb();
    return {R_control, G_control, B_control};
  endfunction

  initial begin : main
    logic [3:0] seq [$];
    logic [3:0] prev;
    int overlap, dcnt;
    @(negedge clk);
    cmp_en = 1'b1;
    // 1: reset state then idle colour after the first frame boundary
    idle_color = 8'hFF;
    check("reset_rgb", 32'(rgb()), 32'h0);
    check("reset_grant", 32'(grant), 32'h0);
    #2 rst = 1'b1;
    wait_fb("t1_fb1");
    check("t1_rgb", 32'({R_control, G_control, B_control}), 32'({3'd7, 3'd7, 2'd3}));
    check("t1_grant_busy", 32'({grant, busy}), 32'h0);
    wait_fb("t1_fb2");

    // 2: single requester, 3-frame hold
    color_in[7:0] = 8'hE0; frames_in[3:0] = 4'd3; req = 4'b0001;
    @(negedge clk);
    check("t2_grant", 32'(grant), 32'h1);
    wait_fb("t2_show");
    check("t2_r_on", 32'(R_control), 32'd7);
    wait_fb("t2_f2");
    check("t2_hold2", 32'(rgb()), 32'hE0);
    wait_fb("t2_f3");
    check("t2_hold3", 32'(rgb()), 32'hE0);
    wait_fb("t2_expire");
    check("t2_idle_back", 32'(rgb()), 32'hFF);
    check("t2_done", 32'(done), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    check("t2_done_single", 32'(done), 32'h0);
    wait_idle("t2_idle");

    // 3: all requesting, ptr=0 -> order 1,2,3,0
    frames_in = 16'h1111; color_in = 32'h1C03_E0FC; req = 4'b1111;
    prev = '0; overlap = 0;
    for (int i = 0; i < 400 && seq.size() < 4; i++) begin
      @(negedge clk);
      if (!$onehot0(grant)) overlap++;
      if (grant != 0 && prev == 0) seq.push_back(grant);
      prev = grant;
    end
    req = 4'b0000;
    check("t3_count", 32'(seq.size()), 32'd4);
    if (seq.size() == 4)
      check("t3_order", 32'({seq[0], seq[1], seq[2], seq[3]}), 32'h248_1);
    check("t3_onehot", 32'(overlap), 32'd0);
    wait_idle("t3_idle");

    // 4: frames=0 behaves as one frame
    color_in[7:0] = 8'h5A; frames_in[3:0] = 4'd0; req = 4'b0001;
    @(negedge clk);
    wait_fb("t4_show");
    check("t4_on", 32'(rgb()), 32'h5A);
    wait_fb("t4_expire");
    check("t4_off", 32'(rgb()), 32'hFF);
    check("t4_done", 32'(done), 32'h1);
    req = 4'b0000;
    wait_idle("t4_idle");

    // 5: abort mid-show drains to idle without done
    color_in[7:0] = 8'h1C; frames_in[3:0] = 4'd5; req = 4'b0001;
    @(negedge clk);
    wait_fb("t5_show");
    @(negedge clk); @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    check("t5_grant_drop", 32'({grant, busy}), 32'h1);
    dcnt = 0;
    for (int i = 0; i < 30 && !m_fb_last; i++) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    check("t5_idle_color", 32'(rgb()), 32'hFF);
    check("t5_no_done", 32'(dcnt), 32'd0);
    wait_idle("t5_idle");

    // 6: reset mid-hold
    color_in[7:0] = 8'h03; frames_in[3:0] = 4'd5; req = 4'b0001;
    @(negedge clk);
    wait_fb("t6_show");
    check("t6_pre", 32'(rgb()), 32'h03);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("t6_async", 32'({grant, done, busy, rgb()}), 32'h0);
    req = 4'b0000;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    wait_fb("t6_fb");
    check("t6_idle", 32'(rgb()), 32'hFF);
    req = 4'b0001;
    @(negedge clk);
    check("t6_regrant", 32'(grant), 32'h1);
    req = 4'b0000;
    wait_idle("t6_idle");

    // Random traffic checked by the per-cycle compare
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 23) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 7) == 0) color_in = $urandom;
      if ($urandom_range(0, 7) == 0) frames_in = 16'($urandom) & 16'h3333;
      if ($urandom_range(0, 63) == 0) idle_color = 8'($urandom);
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
